// File: rtl/jtpopeye_dwnld_pkg.sv
// Shared definitions for the Popeye download sequencer: memory map regions,
// FSM state codes and write-enable bit positions.
package jtpopeye_dwnld_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ioctl address map
  localparam logic [31:0] MAIN_BASE   = 32'h0_0000, MAIN_SIZE   = 32'h8000;
  localparam logic [31:0] OBJ_BASE    = 32'h0_8000, OBJ_SIZE    = 32'h8000;
  localparam logic [31:0] CHAR_BASE   = 32'h1_0000, CHAR_SIZE   = 32'h0800;
  localparam logic [31:0] PALBG_BASE  = 32'h1_0800, PALBG_SIZE  = 32'h0020;
  localparam logic [31:0] PALFG_BASE  = 32'h1_0820, PALFG_SIZE  = 32'h0020;
  localparam logic [31:0] PALOBJ_BASE = 32'h1_0840, PALOBJ_SIZE = 32'h0100;

  // bit positions in the map's 9-bit write one-hot; [7:0] is prom_we, [8] is main_we
  localparam int WE_OBJ0   = 0;
  localparam int WE_CHAR   = 4;
  localparam int WE_PALBG  = 5;
  localparam int WE_PALFG  = 6;
  localparam int WE_PALOBJ = 7;
  localparam int WE_MAIN   = 8;

  function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                     input logic [31:0] size);
    return (a >= base) && (a < base + size);
  endfunction

endpackage

// File: rtl/jtpopeye_dwnld_if.sv
// Download bus: ioctl stream in, memory load bus out.
// Optional chksum signal present when JTPOPEYE_DWNLD_CHKSUM_EN is defined.
interface jtpopeye_dwnld_if #(parameter int AW = 22);
  logic          downloading;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_data;
  logic          ioctl_wr;
  logic [14:0]   prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic [7:0]    prom_we;
  logic          main_we;
  logic          rom_ready;
  logic          overflow;
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  logic [15:0]   chksum;
`endif

  // framework side
  modport master (
    output downloading, ioctl_addr, ioctl_data, ioctl_wr,
    input  prog_addr, prog_data, prog_mask, prom_we, main_we, rom_ready, overflow
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    , input chksum
`endif
  );

  // sequencer side
  modport slave (
    input  downloading, ioctl_addr, ioctl_data, ioctl_wr,
    output prog_addr, prog_data, prog_mask, prom_we, main_we, rom_ready, overflow
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    , output chksum
`endif
  );
endinterface

// File: rtl/jtpopeye_dwnld_map.sv
// Combinational address decoder: ioctl byte address -> target write strobe,
// offset inside that region, and an out-of-map flag.
module jtpopeye_dwnld_map
  import jtpopeye_dwnld_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic [AW-1:0] addr,
  output logic [8:0]    we,
  output logic [14:0]   offset,
  output logic          out_of_map
);
  logic [31:0] a;
  assign a = 32'(addr);

  // first matching region wins; regions do not overlap
  always_comb begin
    we         = '0;
    offset     = '0;
    out_of_map = 1'b0;
    if (in_region(a, MAIN_BASE, MAIN_SIZE)) begin
      we[WE_MAIN] = 1'b1;
      offset      = 15'(a - MAIN_BASE);
    end else if (in_region(a, OBJ_BASE, OBJ_SIZE)) begin
      // four 8 kB object PROMs selected by addr[14:13]
      we[WE_OBJ0 +: 4] = 4'b0001 << a[14:13];
      offset           = {2'b00, a[12:0]};
    end else if (in_region(a, CHAR_BASE, CHAR_SIZE)) begin
      we[WE_CHAR] = 1'b1;
      offset      = 15'(a - CHAR_BASE);
    end else if (in_region(a, PALBG_BASE, PALBG_SIZE)) begin
      we[WE_PALBG] = 1'b1;
      offset       = 15'(a - PALBG_BASE);
    end else if (in_region(a, PALFG_BASE, PALFG_SIZE)) begin
      we[WE_PALFG] = 1'b1;
      offset       = 15'(a - PALFG_BASE);
    end else if (in_region(a, PALOBJ_BASE, PALOBJ_SIZE)) begin
      we[WE_PALOBJ] = 1'b1;
      offset        = 15'(a - PALOBJ_BASE);
    end else begin
      out_of_map = 1'b1;
    end
  end
endmodule

// File: rtl/jtpopeye_dwnld.sv
// Download sequencer: converts ioctl write strobes into one-cycle memory
// write pulses, tracks the session (IDLE/LOAD/FLUSH/DONE) and raises
// rom_ready after the post-download flush.
// Optional feature macro: JTPOPEYE_DWNLD_CHKSUM_EN adds a running byte checksum.
module jtpopeye_dwnld
  import jtpopeye_dwnld_pkg::*;
#(
  parameter int FLUSH_CYCLES = 16,
  parameter int AW           = 22
) (
  input logic             clk,
  input logic             rst,
  jtpopeye_dwnld_if.slave bus
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t        state, state_nx;
  logic [FW-1:0] fcnt;
  logic          wr_l, wr_edge, acc, take, fresh;
  logic [8:0]    map_we;
  logic [14:0]   map_off;
  logic          map_oom;
  logic [16:0]   nbytes;

  logic [14:0]   prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic [7:0]    prom_we;
  logic          main_we, rom_ready, overflow;

  jtpopeye_dwnld_map #(.AW(AW)) u_map (
    .addr       (bus.ioctl_addr),
    .we         (map_we),
    .offset     (map_off),
    .out_of_map (map_oom)
  );

  // only a fresh rising strobe while loading counts; a byte arriving as
  // downloading falls is rejected
  assign wr_edge = bus.ioctl_wr & ~wr_l;
  assign acc     = wr_edge & bus.downloading & (state == LOAD);
  assign take    = acc & ~map_oom;
  // start of a new session: per-session state (overflow, counters) clears
  assign fresh   = (state == IDLE || state == DONE) && (state_nx == LOAD);

  // strobe history for edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) wr_l <= 1'b0;
    else     wr_l <= bus.ioctl_wr;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.downloading) state_nx = LOAD;
      LOAD:    if (!bus.downloading) state_nx = FLUSH;
      FLUSH:   if (bus.downloading) state_nx = LOAD;
               else if (fcnt == '0) state_nx = DONE;
      DONE:    if (bus.downloading) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // flush down-counter, reloaded on every entry into FLUSH
  always_ff @(posedge clk or posedge rst)
    if (rst)                                       fcnt <= '0;
    else if (state_nx == FLUSH && state != FLUSH)  fcnt <= FW'(FLUSH_CYCLES - 1);
    else if (state == FLUSH && fcnt != '0)         fcnt <= fcnt - 1'b1;

  // registered load bus: strobes live one cycle, address/data/mask hold
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= '0;
      prom_we   <= '0;
      main_we   <= 1'b0;
      rom_ready <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      prom_we   <= '0;
      main_we   <= 1'b0;
      rom_ready <= (state_nx == DONE);
      if (take) begin
        prom_we   <= map_we[WE_PALOBJ:WE_OBJ0];
        main_we   <= map_we[WE_MAIN];
        prog_addr <= map_off;
        prog_data <= bus.ioctl_data;
        prog_mask <= bus.ioctl_addr[0] ? 2'b01 : 2'b10;
      end
      if (fresh)            overflow <= 1'b0;
      else if (acc & map_oom) overflow <= 1'b1;
    end

  // saturating count of accepted in-map bytes
  always_ff @(posedge clk or posedge rst)
    if (rst)                        nbytes <= '0;
    else if (fresh)                 nbytes <= '0;
    else if (take && nbytes != '1)  nbytes <= nbytes + 17'd1;

  assign bus.prog_addr = prog_addr;
  assign bus.prog_data = prog_data;
  assign bus.prog_mask = prog_mask;
  assign bus.prom_we   = prom_we;
  assign bus.main_we   = main_we;
  assign bus.rom_ready = rom_ready;
  assign bus.overflow  = overflow;

`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
  logic [15:0] sum;
  // running sum; only LOAD accepts bytes, so it freezes from FLUSH onward
  always_ff @(posedge clk or posedge rst)
    if (rst)        sum <= '0;
    else if (fresh) sum <= '0;
    else if (take)  sum <= sum + 16'(bus.ioctl_data);
  assign bus.chksum = sum;
`endif
endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// Bench for jtpopeye_dwnld: directed checks with literal values plus a
// randomized byte stream compared every cycle against a behavioural model.
// Checks chksum too when JTPOPEYE_DWNLD_CHKSUM_EN is defined.
module tb_jtpopeye_dwnld;
  localparam int AW    = 22;
  localparam int FLUSH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors  = 0;

  jtpopeye_dwnld_if #(.AW(AW)) bus ();
  jtpopeye_dwnld #(.FLUSH_CYCLES(FLUSH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference map: returns write target (0-7 prom bit, 8 main, -1 none) and offset
  function automatic void lookup(input int unsigned a, output int we, output int off);
    int unsigned base [6] = '{32'h0, 32'h8000, 32'h10000, 32'h10800, 32'h10820, 32'h10840};
    int unsigned size [6] = '{32'h8000, 32'h8000, 32'h800, 32'h20, 32'h20, 32'h100};
    we  = -1;
    off = 0;
    for (int r = 0; r < 6; r++)
      if (a >= base[r] && a - base[r] < size[r]) begin
        off = int'(a - base[r]);
        case (r)
          0:       we = 8;
          1:       begin we = off / 8192; off = off % 8192; end
          default: we = r + 2;
        endcase
      end
  endfunction

  // behavioural model, advanced on each clock with that cycle's inputs
  bit          m_loading = 0, m_ready = 0, m_ovf = 0, m_prev_wr = 0, m_pulse = 0;
  int          m_flush = 0;
  logic [7:0]  m_prom = '0;
  logic        m_main = 1'b0;
  logic [14:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [1:0]  m_mask = '0;
  logic [15:0] m_sum  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_loading = 0; m_ready = 0; m_ovf = 0; m_prev_wr = 0; m_pulse = 0; m_flush = 0;
      m_prom = '0; m_main = 1'b0; m_addr = '0; m_data = '0; m_mask = '0; m_sum = '0;
    end else begin
      bit e;
      int we, off;
      e = bus.ioctl_wr && !m_prev_wr;
      m_prev_wr = bus.ioctl_wr;
      m_prom = '0; m_main = 1'b0; m_pulse = 0;
      if (m_loading && bus.downloading && e) begin
        lookup(32'(bus.ioctl_addr), we, off);
        if (we < 0) m_ovf = 1;
        else begin
          m_pulse = 1;
          if (we == 8) m_main = 1'b1;
          else         m_prom = 8'(1 << we);
          m_addr = 15'(off);
          m_data = bus.ioctl_data;
          m_mask = bus.ioctl_addr[0] ? 2'b01 : 2'b10;
          m_sum  = m_sum + 16'(bus.ioctl_data);
        end
      end
      if (m_loading) begin
        if (!bus.downloading) begin m_loading = 0; m_flush = FLUSH; end
      end else if (m_flush > 0) begin
        if (bus.downloading) begin m_loading = 1; m_flush = 0; end
        else begin
          m_flush--;
          if (m_flush == 0) m_ready = 1;
        end
      end else if (bus.downloading) begin
        m_loading = 1; m_ready = 0; m_ovf = 0; m_sum = '0;
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("prom_we",   32'(bus.prom_we),   32'(m_prom));
    check("main_we",   32'(bus.main_we),   32'(m_main));
    check("rom_ready", 32'(bus.rom_ready), 32'(m_ready));
    check("overflow",  32'(bus.overflow),  32'(m_ovf));
    if (m_pulse) begin
      check("prog_addr", 32'(bus.prog_addr), 32'(m_addr));
      check("prog_data", 32'(bus.prog_data), 32'(m_data));
      check("prog_mask", 32'(bus.prog_mask), 32'(m_mask));
    end
`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    check("chksum", 32'(bus.chksum), 32'(m_sum));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input int unsigned a, input logic [7:0] d);
    bus.ioctl_addr = AW'(a);
    bus.ioctl_data = d;
    bus.ioctl_wr   = 1'b1;
    tick();
  endtask

  function automatic int unsigned rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return $urandom_range(0, 32'h7FFF);
      3, 4:    return $urandom_range(32'h8000, 32'hFFFF);
      5:       return $urandom_range(32'h10000, 32'h107FF);
      6:       return $urandom_range(32'h10800, 32'h1081F);
      7:       return $urandom_range(32'h10820, 32'h1083F);
      8:       return $urandom_range(32'h10840, 32'h1093F);
      default: return $urandom_range(32'h10940, 32'h3FFFFF);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.downloading = 1'b0;
    bus.ioctl_addr  = '0;
    bus.ioctl_data  = '0;
    bus.ioctl_wr    = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst prom_we",   32'(bus.prom_we),   32'h0);
    check("rst main_we",   32'(bus.main_we),   32'h0);
    check("rst rom_ready", 32'(bus.rom_ready), 32'h0);
    check("rst overflow",  32'(bus.overflow),  32'h0);
    check("rst prog_addr", 32'(bus.prog_addr), 32'h0);
    rst = 1'b0;
    bus.downloading = 1'b1;
    tick();

    // obj 1e PROM byte
    put(32'h08005, 8'hA5);
    check("t1 prom_we",   32'(bus.prom_we),   32'h01);
    check("t1 prog_addr", 32'(bus.prog_addr), 32'h5);
    check("t1 prog_data", 32'(bus.prog_data), 32'hA5);
    bus.ioctl_wr = 1'b0;
    tick();
    check("t1 one cycle", 32'(bus.prom_we), 32'h0);

    // strobe held 4 cycles -> single pulse on obj 1k
    put(32'h0E001, 8'h3C);
    check("t2 prom_we",   32'(bus.prom_we),   32'h08);
    check("t2 prog_addr", 32'(bus.prog_addr), 32'h1);
    repeat (3) begin
      tick();
      check("t2 no repeat", 32'(bus.prom_we), 32'h0);
    end
    bus.ioctl_wr = 1'b0;
    tick();

    // main ROM even/odd lanes
    put(32'h0, 8'h11);
    check("t3 main_we even", 32'(bus.main_we),   32'h1);
    check("t3 mask even",    32'(bus.prog_mask), 32'h2);
    bus.ioctl_wr = 1'b0;
    tick();
    put(32'h1, 8'h22);
    check("t3 main_we odd", 32'(bus.main_we),   32'h1);
    check("t3 mask odd",    32'(bus.prog_mask), 32'h1);
    check("t3 addr odd",    32'(bus.prog_addr), 32'h1);
    bus.ioctl_wr = 1'b0;
    tick();

    // just past the map, then first obj palette byte
    put(32'h10940, 8'h77);
    check("t4 no prom", 32'(bus.prom_we),  32'h0);
    check("t4 no main", 32'(bus.main_we),  32'h0);
    check("t4 ovf",     32'(bus.overflow), 32'h1);
    bus.ioctl_wr = 1'b0;
    tick();
    put(32'h10840, 8'h99);
    check("t4 prom_we",   32'(bus.prom_we),   32'h80);
    check("t4 prog_addr", 32'(bus.prog_addr), 32'h0);
    bus.ioctl_wr = 1'b0;
    tick();

    // flush timing and re-entry
    bus.downloading = 1'b0;
    for (int i = 1; i <= FLUSH + 1; i++) begin
      tick();
      if (i == FLUSH) check("t5 not ready yet", 32'(bus.rom_ready), 32'h0);
    end
    check("t5 ready", 32'(bus.rom_ready), 32'h1);
    bus.downloading = 1'b1;
    tick();
    check("t5 ready drop", 32'(bus.rom_ready), 32'h0);
    check("t5 ovf clear",  32'(bus.overflow),  32'h0);

`ifdef JTPOPEYE_DWNLD_CHKSUM_EN
    put(32'h10000, 8'hFF);
    bus.ioctl_wr = 1'b0;
    tick();
    put(32'h10001, 8'h02);
    bus.ioctl_wr = 1'b0;
    tick();
    check("t6 chksum", 32'(bus.chksum), 32'h0101);
`endif

    // reset with a byte about to be accepted
    bus.ioctl_addr = AW'(32'h10005);
    bus.ioctl_data = 8'h5A;
    bus.ioctl_wr   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t6 rst prog_data", 32'(bus.prog_data), 32'h0);
    tick();
    check("t6 rst prom_we",   32'(bus.prom_we),   32'h0);
    check("t6 rst main_we",   32'(bus.main_we),   32'h0);
    check("t6 rst prog_addr", 32'(bus.prog_addr), 32'h0);
    check("t6 rst prog_mask", 32'(bus.prog_mask), 32'h0);
    check("t6 rst overflow",  32'(bus.overflow),  32'h0);
    rst = 1'b0;
    bus.ioctl_wr = 1'b0;
    tick();

    // randomized stream, with session drops, flush re-entries and late bytes
    for (int n = 0; n < 300; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        bus.downloading = 1'b0;
        repeat ($urandom_range(1, 24)) tick();
        bus.downloading = 1'b1;
        tick();
      end else if (sel == 1) begin
        bus.ioctl_addr  = AW'(rand_addr());
        bus.ioctl_data  = 8'($urandom);
        bus.ioctl_wr    = 1'b1;
        bus.downloading = 1'b0;
        tick();
        bus.ioctl_wr = 1'b0;
        repeat (3) tick();
        bus.downloading = 1'b1;
        tick();
      end else begin
        put(rand_addr(), 8'($urandom));
        repeat ($urandom_range(0, 2)) tick();
        bus.ioctl_wr = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    bus.ioctl_wr    = 1'b0;
    bus.downloading = 1'b0;
    repeat (FLUSH + 4) tick();
    check("final ready", 32'(bus.rom_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
